// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO feeding a UART transmitter, timing each frame from the baud select
module uart_tx_feeder #(
  parameter int DEPTH      = 16,
  parameter int DIV0       = 5208,
  parameter int DIV1       = 2604,
  parameter int DIV2       = 1302,
  parameter int DIV3       = 434,
  parameter int FRAME_BITS = 11,
  parameter int GUARD      = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               sel,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     TX_start,
  output logic [7:0]               TX_DATA,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t      state, state_nxt;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic [31:0] cnt, bit_last, wait_last;
  logic        full, empty, push, pop;

  function automatic logic [31:0] div_of(input logic [1:0] s);
    case (s)
      2'b00:   div_of = 32'(DIV0);
      2'b01:   div_of = 32'(DIV1);
      2'b10:   div_of = 32'(DIV2);
      default: div_of = 32'(DIV3);
    endcase
  endfunction

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = !full && !reset;
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && !empty;
  assign count    = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty)              state_nxt = START;
      START:   if (cnt == bit_last)     state_nxt = WAIT;
      WAIT:    if (cnt == wait_last)    state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    TX_start = (state == START);
    busy     = (state != IDLE);
  end

  // Baud is captured once per frame at load, so sel changes mid-frame are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      bit_last  <= '0;
      wait_last <= '0;
      TX_DATA   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            TX_DATA   <= mem[rd_ptr[AW-1:0]];
            bit_last  <= div_of(sel) - 32'd1;
            wait_last <= 32'(FRAME_BITS - 1) * div_of(sel) + 32'(GUARD) - 32'd1;
            cnt       <= '0;
          end
        end
        START:   cnt <= (cnt == bit_last) ? '0 : cnt + 32'd1;
        WAIT:    cnt <= cnt + 32'd1;
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sel;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       TX_start;
  logic [7:0] TX_DATA;
  logic       busy;
  logic [2:0] count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hold_err = 0;
  int hi_cnt = 0;
  logic prev_start = 1'b0;
  logic prev_busy = 1'b0;
  int rise_cyc[$];
  logic [7:0] rise_dat[$];
  int hi_len[$];
  int busy_fall[$];

  uart_tx_feeder #(
    .DEPTH(4), .DIV0(4), .DIV1(2), .DIV2(8), .DIV3(1), .FRAME_BITS(11), .GUARD(2)
  ) dut (
    .clk(clk), .reset(reset), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .TX_start(TX_start), .TX_DATA(TX_DATA), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records each TX_start pulse: rise cycle, byte, width, and any TX_DATA wobble while high.
  always @(negedge clk) begin
    if (TX_start && !prev_start) begin
      rise_cyc.push_back(cyc);
      rise_dat.push_back(TX_DATA);
      hi_cnt = 1;
    end else if (TX_start) begin
      hi_cnt++;
      if (TX_DATA !== rise_dat[$]) hold_err++;
    end
    if (!TX_start && prev_start) hi_len.push_back(hi_cnt);
    if (!busy && prev_busy) busy_fall.push_back(cyc);
    prev_start = TX_start;
    prev_busy  = busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    rise_cyc.delete();
    rise_dat.delete();
    hi_len.delete();
    busy_fall.delete();
  endtask

  int c0;
  int t3;
  logic [7:0] burst [5];
  logic [7:0] fill [6];
  logic [2:0] seq[$];
  int seq_cyc[$];

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h77; sel = 2'b00;

    // reset held with a producer pushing
    tick(); tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_tx_start", TX_start, 0);
    check("rst_tx_data", TX_DATA, 8'h00);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    check("rst_no_write", count, 0);
    clear_log();

    // single byte at 4-cycle bit
    sel = 2'b00; in_data = 8'hA5; in_valid = 1'b1; c0 = cyc;
    tick();
    in_valid = 1'b0;
    repeat (60) tick();
    check("single_rises", rise_cyc.size(), 1);
    check("single_latency", rise_cyc[0] - c0, 2);
    check("single_data", rise_dat[0], 8'hA5);
    check("single_width", hi_len[0], 4);
    check("single_busy_len", busy_fall[0] - rise_cyc[0], 46);
    check("single_hold", hold_err, 0);
    clear_log();

    // burst of five: first is popped while the rest fill the FIFO
    burst[0] = 8'h55; burst[1] = 8'hAA; burst[2] = 8'h0F; burst[3] = 8'hF0; burst[4] = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = burst[i];
      check($sformatf("burst_ready%0d", i), in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    check("burst_count_full", count, 4);
    check("burst_not_ready", in_ready, 0);
    repeat (250) tick();
    check("burst_rises", rise_cyc.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("burst_data%0d", i), rise_dat[i], burst[i]);
    for (int i = 0; i < 4; i++) check($sformatf("burst_gap%0d", i), rise_cyc[i+1] - rise_cyc[i], 47);
    check("burst_hold", hold_err, 0);
    check("burst_drained", count, 0);
    clear_log();

    // sel change mid-frame only affects the following frame
    sel = 2'b01;
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33; tick();
    in_valid = 1'b0;
    check("sel_mid_start", TX_start, 1);
    sel = 2'b11;
    repeat (80) tick();
    check("sel_rises", rise_cyc.size(), 3);
    check("sel_width0", hi_len[0], 2);
    check("sel_width1", hi_len[1], 1);
    check("sel_period0", rise_cyc[1] - rise_cyc[0], 25);
    check("sel_period1", rise_cyc[2] - rise_cyc[1], 14);
    check("sel_data1", rise_dat[1], 8'h22);
    clear_log();

    // full FIFO with producer held while the FSM pops
    fill[0] = 8'hC1; fill[1] = 8'hC2; fill[2] = 8'hC3; fill[3] = 8'hC4; fill[4] = 8'hC5; fill[5] = 8'hC6;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = fill[i];
      tick();
    end
    in_data = fill[5];
    check("full_count", count, 4);
    check("full_not_ready", in_ready, 0);
    seq.push_back(count);
    seq_cyc.push_back(cyc);
    for (int k = 0; k < 30 && seq.size() < 3; k++) begin
      tick();
      if (count !== seq[$]) begin
        seq.push_back(count);
        seq_cyc.push_back(cyc);
      end
    end
    in_valid = 1'b0;
    check("full_seq_len", seq.size(), 3);
    check("full_seq0", seq[0], 4);
    check("full_seq1", seq[1], 3);
    check("full_seq2", seq[2], 4);
    check("full_one_cycle", seq_cyc[2] - seq_cyc[1], 1);
    repeat (90) tick();
    check("full_rises", rise_cyc.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("full_data%0d", i), rise_dat[i], fill[i]);
    check("full_drained", count, 0);
    clear_log();

    // reset during START with bytes queued
    sel = 2'b00;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h90 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    check("abort_in_start", TX_start, 1);
    check("abort_queued", count, 3);
    reset = 1'b1;
    #1;
    check("abort_ready_low", in_ready, 0);
    tick();
    check("abort_tx_start", TX_start, 0);
    check("abort_busy", busy, 0);
    check("abort_count", count, 0);
    reset = 1'b0;
    repeat (100) tick();
    check("abort_no_frames", rise_cyc.size(), 1);
    check("abort_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
